mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build is fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_cs,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e              state_q, state_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_we_n_q, ram_we_n_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                grant_valid;
    logic                grant_id;

    assign grant_valid = req0 | req1;

`ifdef MEM_ARB_RR_EN
    // prio_q names the port that wins the next tie; it flips to the loser on every grant.
    logic prio_q, prio_d;

    always_comb begin
        prio_d   = prio_q;
        grant_id = (req0 && req1) ? prio_q : req1;
        if (state_q == IDLE && grant_valid) prio_d = ~grant_id;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
`else
    // Only meaningful when grant_valid: port 0 wins whenever it asks.
    assign grant_id = ~req0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from a default so no branch can infer a latch.
        win_d      = win_q;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_cs_d   = 1'b0;
        ram_we_n_d = 1'b1;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    win_d      = grant_id;
                    we_d       = grant_id ? we1 : we0;
                    ram_addr_d = grant_id ? addr1 : addr0;
                    ram_din_d  = grant_id ? wdata1 : wdata0;
                    ram_cs_d   = 1'b1;
                    ram_we_n_d = ~we_d;
                end
            end
            ACCESS: begin
                ack0_d = ~win_q;
                ack1_d = win_q;
                if (!we_q) begin
                    if (win_q) rdata1_d = ram_dout;
                    else       rdata0_d = ram_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_n_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            win_q      <= win_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_cs_q   <= ram_cs_d;
            ram_we_n_q <= ram_we_n_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign ram_cs       = ram_cs_q;
    assign ram_write_en = ram_we_n_q;
    assign ram_addr     = ram_addr_q;
    assign ram_din      = ram_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus random transactions against a
// transaction-level model (memory array, expected read data, tie-break pointer).
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_cs, ram_write_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] ram_model [2**AW] = '{default: '0};
    logic [DW-1:0] ref_mem   [2**AW];
    logic [DW-1:0] exp_rd    [2];
    bit            ptr;
    bit            win;
    bit [1:0]      rq;
    int            n_g1;
    int            n_cmp, n_bad;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs(ram_cs), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // External RAM: combinational read, write on the edge ending an active-low strobe cycle.
    assign ram_dout = ram_model[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && !ram_write_en) ram_model[ram_addr] <= ram_din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Tie goes to the pointer under round-robin, to port 0 otherwise; a lone requester always wins.
    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && r1) return RR ? ptr : 1'b0;
        return r1;
    endfunction

    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit            w_win;
        bit            g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g     = pick(r0, r1);
        ptr   = !g;
        w_win = g ? w1 : w0;
        a     = g ? a1 : a0;
        d     = g ? d1 : d0;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        tick();
        check("acc_cs", ram_cs, 1'b1);
        check("acc_we_n", ram_write_en, !w_win);
        check("acc_addr", ram_addr, a);
        check("acc_din", ram_din, d);
        check("acc_ack", {ack1, ack0}, 2'b00);
        // Inputs changed after latching must have no effect.
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = AW'($urandom); addr1 = AW'($urandom);
        wdata0 = DW'($urandom); wdata1 = DW'($urandom);
        if (w_win) ref_mem[a] = d;
        else       exp_rd[g] = ref_mem[a];
        tick();
        check("done_ack", {ack1, ack0}, g ? 2'b10 : 2'b01);
        check("done_cs", ram_cs, 1'b0);
        check("done_we_n", ram_write_en, 1'b1);
        check("rdata0", rdata0, exp_rd[0]);
        check("rdata1", rdata1, exp_rd[1]);
        tick();
        check("idle_ack", {ack1, ack0}, 2'b00);
        check("idle_cs", ram_cs, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; ptr = 1'b0; n_g1 = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;

        // Reset held two cycles with a request pending: reset must dominate.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
        addr0 = 4'h3; addr1 = 4'h9; wdata0 = 4'h5; wdata1 = 4'h6;
        tick(); tick();
        check("rst_cs", ram_cs, 1'b0);
        check("rst_we_n", ram_write_en, 1'b1);
        check("rst_addr", ram_addr, '0);
        check("rst_din", ram_din, '0);
        check("rst_ack", {ack1, ack0}, 2'b00);
        check("rst_rdata0", rdata0, '0);
        check("rst_rdata1", rdata1, '0);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        check("post_rst_cs", ram_cs, 1'b0);
        check("post_rst_ack", {ack1, ack0}, 2'b00);

        // Preload every cell with random data through randomly chosen ports.
        for (int i = 0; i < 2**AW; i++) begin
            if ($urandom_range(0, 1) == 0)
                run_txn(1'b1, 1'b0, 1'b1, 1'b0, AW'(i), AW'($urandom), DW'($urandom), DW'($urandom));
            else
                run_txn(1'b0, 1'b1, 1'b0, 1'b1, AW'($urandom), AW'(i), DW'($urandom), DW'($urandom));
        end

        // Port 0 write then read of address 5.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'hA, 4'h0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 4'h3, 4'h0);
        check("rd5_value", rdata0, 4'hA);

        // Port 1 writes the top cell, port 0 reads it; rdata1 must keep its old value.
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        check("rd15_value", rdata0, 4'hF);

        // req0 held for four consecutive reads: one ack every third cycle.
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 4'h0; wdata0 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            ptr = 1'b1;
            tick();
            check("burst_cs", ram_cs, 1'b1);
            check("burst_addr", ram_addr, AW'(i));
            tick();
            exp_rd[0] = ref_mem[i];
            check("burst_ack", {ack1, ack0}, 2'b01);
            check("burst_rdata", rdata0, exp_rd[0]);
            addr0 = AW'(i + 1);
            if (i == 3) req0 = 1'b0;
            tick();
            check("burst_gap", {ack1, ack0}, 2'b00);
        end

        // Both ports held: alternate under round-robin, port 0 every time otherwise.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'h3; addr1 = 4'hC;
        for (int i = 0; i < 6; i++) begin
            win = pick(1'b1, 1'b1);
            ptr = !win;
            tick();
            check("tie_addr", ram_addr, win ? 4'hC : 4'h3);
            tick();
            exp_rd[win] = ref_mem[win ? 4'hC : 4'h3];
            if (ack1) n_g1++;
            check("tie_ack", {ack1, ack0}, win ? 2'b10 : 2'b01);
            check("tie_rdata0", rdata0, exp_rd[0]);
            check("tie_rdata1", rdata1, exp_rd[1]);
            if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            check("tie_gap", {ack1, ack0}, 2'b00);
        end
        check("tie_port1_grants", n_g1, RR ? 3 : 0);

        // Reset sampled during ACCESS of a write aborts it: no ack afterwards.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 4'h6;
        tick();
        check("abort_acc_cs", ram_cs, 1'b1);
        check("abort_acc_we_n", ram_write_en, 1'b0);
        rst = 1'b1; req0 = 1'b0;
        tick();
        ref_mem[7] = 4'h6;
        ptr = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        check("abort_cs", ram_cs, 1'b0);
        check("abort_we_n", ram_write_en, 1'b1);
        check("abort_ack", {ack1, ack0}, 2'b00);
        check("abort_addr", ram_addr, '0);
        check("abort_rdata0", rdata0, '0);
        rst = 1'b0;
        tick();
        check("abort_ack_1", {ack1, ack0}, 2'b00);
        check("abort_cs_1", ram_cs, 1'b0);
        tick();
        check("abort_ack_2", {ack1, ack0}, 2'b00);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 4'h0, 4'h0);
        check("abort_reread", rdata1, 4'h6);

        // Random mix of single and simultaneous requests.
        for (int i = 0; i < 60; i++) begin
            rq = 2'($urandom_range(1, 3));
            run_txn(rq[0], rq[1], 1'($urandom), 1'($urandom),
                    AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
